// File: rtl/lcd_pkg.sv
// Shared definitions for the RGB-LCD timing controller.
//   - default timing for the 480x272 RGB565 panel
//   - line/frame total helper
//   - controller state encoding
package lcd_pkg;

    localparam int PCLK_DIV_DEF     = 4;
    localparam int H_SYNC_DEF       = 41;
    localparam int H_BACK_DEF       = 2;
    localparam int H_ACTIVE_DEF     = 480;
    localparam int H_FRONT_DEF      = 2;
    localparam int V_SYNC_DEF       = 10;
    localparam int V_BACK_DEF       = 2;
    localparam int V_ACTIVE_DEF     = 272;
    localparam int V_FRONT_DEF      = 2;
    localparam int PWRUP_FRAMES_DEF = 2;
    localparam int DATA_W_DEF       = 16;

    // Total period of one line (in pixels) or one frame (in lines).
    function automatic int line_total(input int sync, input int back,
                                      input int active, input int front);
        return sync + back + active + front;
    endfunction

    localparam int H_TOTAL_DEF = line_total(H_SYNC_DEF, H_BACK_DEF, H_ACTIVE_DEF, H_FRONT_DEF);
    localparam int V_TOTAL_DEF = line_total(V_SYNC_DEF, V_BACK_DEF, V_ACTIVE_DEF, V_FRONT_DEF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PWR_ON = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        OFF    = 3'd4
    } lcd_state_t;

endpackage

// File: rtl/lcd_tick_gen.sv
// Pixel-rate tick generator for sys_clk-domain peripherals.
//   sys_clk   in   system clock
//   sys_rst   in   asynchronous active-low reset
//   tick      out  one-sys_clk strobe on the last cycle of each pixel period
//   lcd_pclk  out  registered pixel clock, low for the first half of the period
module lcd_tick_gen #(
    parameter int PCLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick,
    output logic lcd_pclk
);
    localparam int DIV_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PCLK_DIV / 2);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;

    assign tick    = (div == DIV_LAST);
    assign div_nxt = tick ? '0 : div + 1'b1;

    // pclk is registered from the next divider value so it tracks div exactly;
    // its rising edge lands mid-pixel, away from the data update on tick.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            div      <= '0;
            lcd_pclk <= 1'b0;
        end else begin
            div      <= div_nxt;
            lcd_pclk <= (div_nxt >= DIV_HALF);
        end
    end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// RGB-LCD timing generator and panel power sequencer (single sys_clk domain).
//   sys_clk/sys_rst      clock, asynchronous active-low reset
//   enable               1 = display on, 0 = orderly shutdown
//   pix_req/pix_x/pix_y  request for the pixel shown one pixel period later
//   pix_data             source pixel for the last request
//   lcd_*                panel pins (pclk, hs/vs active low, de, rgb, disp, bl)
//   frame_start          strobe when the position returns to (0,0)
//   busy                 controller not idle
//
// state  | meaning
// IDLE   | panel off, counters held at 0, syncs inactive
// PWR_ON | disp on, timing running, blank frames before backlight
// RUN    | backlight on, pixels requested and displayed
// DRAIN  | enable dropped, finishing the current frame with data
// OFF    | backlight off, one blank frame before disp goes low
module lcd_timing_ctrl
    import lcd_pkg::*;
#(
    parameter int PCLK_DIV     = PCLK_DIV_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BACK       = H_BACK_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_FRONT      = H_FRONT_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BACK       = V_BACK_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_FRONT      = V_FRONT_DEF,
    parameter int PWRUP_FRAMES = PWRUP_FRAMES_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    output logic              pix_req,
    output logic [10:0]       pix_x,
    output logic [9:0]        pix_y,
    input  logic [DATA_W-1:0] pix_data,
    output logic              lcd_pclk,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_rgb,
    output logic              lcd_disp,
    output logic              lcd_bl,
    output logic              frame_start,
    output logic              busy
);
    localparam int H_TOTAL = line_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOTAL = line_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_E  = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_E  = 10'(V_SYNC);
    localparam logic [9:0]  V_ACT_BEG = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_ACT_END = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [7:0]  PWR_LOAD  = 8'(PWRUP_FRAMES - 1);

    function automatic logic is_active(input logic [10:0] h, input logic [9:0] v);
        return (h >= H_ACT_BEG) && (h < H_ACT_END) && (v >= V_ACT_BEG) && (v < V_ACT_END);
    endfunction

    logic       tick;
    lcd_state_t state, state_nxt;
    logic [10:0] h_cnt, h1, h2;
    logic [9:0]  v_cnt, v1, v2;
    logic [7:0]  pwr_left;
    logic        frame_end;
    logic        show;

    lcd_tick_gen #(.PCLK_DIV(PCLK_DIV)) u_tick (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tick     (tick),
        .lcd_pclk (lcd_pclk)
    );

    // h1/v1: position that becomes current on this tick.
    // h2/v2: the one after it, which is what gets requested (one pixel ahead).
    always_comb begin
        h1 = '0;
        v1 = '0;
        if (state != IDLE) begin
            if (h_cnt == H_LAST) begin
                v1 = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h1 = h_cnt + 1'b1;
                v1 = v_cnt;
            end
        end
        if (h1 == H_LAST) begin
            h2 = '0;
            v2 = (v1 == V_LAST) ? '0 : v1 + 1'b1;
        end else begin
            h2 = h1 + 1'b1;
            v2 = v1;
        end
    end

    assign frame_end = (state != IDLE) && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = PWR_ON;
            PWR_ON:  if (!enable) state_nxt = OFF;
                     else if (frame_end && (pwr_left == '0)) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN:   if (enable) state_nxt = RUN;
                     else if (frame_end) state_nxt = OFF;
            OFF:     if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DE and data are shown only with the backlight on; power-up frames stay blank.
    assign show = (state_nxt == RUN) || (state_nxt == DRAIN);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pwr_left    <= '0;
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            lcd_hs      <= 1'b1;
            lcd_vs      <= 1'b1;
            lcd_de      <= 1'b0;
            lcd_rgb     <= '0;
            lcd_disp    <= 1'b0;
            lcd_bl      <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                state <= state_nxt;
                busy  <= (state_nxt != IDLE);
                if (state == IDLE)
                    pwr_left <= PWR_LOAD;
                else if ((state == PWR_ON) && frame_end)
                    pwr_left <= pwr_left - 1'b1;
                if (state_nxt == IDLE) begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                end else begin
                    h_cnt <= h1;
                    v_cnt <= v1;
                end
                lcd_hs      <= (state_nxt == IDLE) || (h1 >= H_SYNC_E);
                lcd_vs      <= (state_nxt == IDLE) || (v1 >= V_SYNC_E);
                lcd_disp    <= (state_nxt != IDLE);
                lcd_bl      <= show;
                lcd_de      <= show && is_active(h1, v1);
                lcd_rgb     <= (show && is_active(h1, v1)) ? pix_data : '0;
                frame_start <= (state_nxt != IDLE) && (h1 == '0) && (v1 == '0);
                if (show && is_active(h2, v2)) begin
                    pix_req <= 1'b1;
                    pix_x   <= h2 - H_ACT_BEG;
                    pix_y   <= v2 - V_ACT_BEG;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
module tb_lcd_timing_ctrl;
    localparam int PDIV = 4;
    localparam int HS = 2, HB = 2, HA = 4, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int TOT = HT * VT;
    localparam int PWRUP = 1;
    localparam int M_IDLE = 0, M_PWR = 1, M_RUN = 2, M_DRAIN = 3, M_OFF = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic        pix_req;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;
    logic        lcd_pclk, lcd_hs, lcd_vs, lcd_de, lcd_disp, lcd_bl, frame_start, busy;
    logic [15:0] lcd_rgb;

    lcd_timing_ctrl #(
        .PCLK_DIV(PDIV), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .PWRUP_FRAMES(PWRUP), .DATA_W(16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .lcd_pclk(lcd_pclk), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
        .lcd_rgb(lcd_rgb), .lcd_disp(lcd_disp), .lcd_bl(lcd_bl),
        .frame_start(frame_start), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Frame source: returns {row, column} of the requested pixel.
    assign pix_data = {pix_y[7:0], pix_x[7:0]};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Position is a single linear pixel index within the frame.
    int   cyc, mode, pos, pfr;
    logic m_pclk, m_hs, m_vs, m_de, m_disp, m_bl, m_busy, m_req, m_fs, m_ticked;
    logic [15:0] m_rgb;
    logic [10:0] m_x;
    logic [9:0]  m_y;

    function automatic bit active_at(input int p);
        int h, v;
        h = p % HT;
        v = p / HT;
        return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    always @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cyc = 0; mode = M_IDLE; pos = 0; pfr = 0;
            m_pclk = 0; m_hs = 1; m_vs = 1; m_de = 0; m_disp = 0; m_bl = 0;
            m_busy = 0; m_req = 0; m_fs = 0; m_ticked = 0;
            m_rgb = '0; m_x = '0; m_y = '0;
        end else begin
            int  nm, np, q;
            bit  tk, wrap, show;
            tk = (cyc % PDIV) == (PDIV - 1);
            cyc++;
            m_pclk   = (cyc % PDIV) >= (PDIV / 2);
            m_req    = 0;
            m_fs     = 0;
            m_ticked = tk;
            if (tk) begin
                wrap = (mode != M_IDLE) && (pos == TOT - 1);
                nm = mode;
                case (mode)
                    M_IDLE:  if (enable) begin nm = M_PWR; pfr = 0; end
                    M_PWR:   if (!enable) nm = M_OFF;
                             else if (wrap) begin pfr++; if (pfr >= PWRUP) nm = M_RUN; end
                    M_RUN:   if (!enable) nm = M_DRAIN;
                    M_DRAIN: if (enable) nm = M_RUN; else if (wrap) nm = M_OFF;
                    default: if (wrap) nm = M_IDLE;
                endcase
                np = (mode == M_IDLE || nm == M_IDLE) ? 0 : (pos + 1) % TOT;
                show   = (nm == M_RUN) || (nm == M_DRAIN);
                m_hs   = (nm == M_IDLE) || ((np % HT) >= HS);
                m_vs   = (nm == M_IDLE) || ((np / HT) >= VS);
                m_disp = (nm != M_IDLE);
                m_busy = (nm != M_IDLE);
                m_bl   = show;
                m_de   = show && active_at(np);
                m_rgb  = m_de ? {8'(np / HT - VS - VB), 8'(np % HT - HS - HB)} : 16'h0;
                m_fs   = (nm != M_IDLE) && (np == 0);
                q = (np + 1) % TOT;
                if (show && active_at(q)) begin
                    m_req = 1;
                    m_x   = 11'(q % HT - HS - HB);
                    m_y   = 10'(q / HT - VS - VB);
                end
                mode = nm;
                pos  = np;
            end
        end
    end

    always @(negedge sys_clk) begin
        check1("pclk", lcd_pclk, m_pclk);
        check1("hs", lcd_hs, m_hs);
        check1("vs", lcd_vs, m_vs);
        check1("de", lcd_de, m_de);
        check1("disp", lcd_disp, m_disp);
        check1("bl", lcd_bl, m_bl);
        check1("busy", busy, m_busy);
        check1("pix_req", pix_req, m_req);
        check1("frame_start", frame_start, m_fs);
        checkv("rgb", int'(lcd_rgb), int'(m_rgb));
        checkv("pix_x", int'(pix_x), int'(m_x));
        checkv("pix_y", int'(pix_y), int'(m_y));
    end

    // ---------------- per-frame statistics ----------------
    int hs_lo, vs_lo, de_n, req_n, last_hs, last_vs, last_de, last_req, pclk_rise;
    bit pclk_prev, bl_seen, bl_low;
    logic [15:0] rgb_q[$];
    logic [15:0] rgb_last[$];
    logic [15:0] exp_rgb [16] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                  16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                  16'h0200, 16'h0201, 16'h0202, 16'h0203,
                                  16'h0300, 16'h0301, 16'h0302, 16'h0303};

    initial begin
        hs_lo = 0; vs_lo = 0; de_n = 0; req_n = 0; pclk_rise = 0;
        last_hs = 0; last_vs = 0; last_de = 0; last_req = 0;
        pclk_prev = 0; bl_seen = 0; bl_low = 0;
    end

    always @(negedge sys_clk) begin
        if (frame_start) begin
            last_hs = hs_lo; last_vs = vs_lo; last_de = de_n; last_req = req_n;
            hs_lo = 0; vs_lo = 0; de_n = 0; req_n = 0;
            rgb_last = rgb_q;
            rgb_q.delete();
        end
        if (!lcd_hs) hs_lo++;
        if (!lcd_vs) vs_lo++;
        if (lcd_de) de_n++;
        if (pix_req) req_n++;
        if (lcd_bl) bl_seen = 1; else bl_low = 1;
        if (m_ticked && lcd_de) rgb_q.push_back(lcd_rgb);
        if (lcd_pclk && !pclk_prev) pclk_rise++;
        pclk_prev = lcd_pclk;
    end

    task automatic wait_fs(input int max);
        bit got;
        got = 0;
        for (int n = 0; n < max; n++) begin
            @(negedge sys_clk);
            if (frame_start) begin got = 1; break; end
        end
        check1("wait_frame_start", got, 1'b1);
        #1;
    endtask

    task automatic wait_idle(input int max, output int waited);
        bit got;
        got = 0;
        waited = 0;
        for (int n = 0; n < max; n++) begin
            @(negedge sys_clk);
            waited++;
            if (!busy) begin got = 1; break; end
        end
        check1("wait_idle", got, 1'b1);
        #1;
    endtask

    task automatic wait_de(input int max);
        bit got;
        got = 0;
        for (int n = 0; n < max; n++) begin
            @(negedge sys_clk);
            if (lcd_de) begin got = 1; break; end
        end
        check1("wait_de", got, 1'b1);
    endtask

    initial begin
        int w;
        sys_rst = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge sys_clk);
        pclk_rise = 0;
        sys_rst = 1'b1;

        // 1: idle with enable low
        repeat (100) @(negedge sys_clk);
        #1;
        checkv("idle_pclk_rises", pclk_rise, 25);
        checkv("idle_req_count", req_n, 0);
        check1("idle_busy", busy, 1'b0);
        check1("idle_hs", lcd_hs, 1'b1);

        // 2: power-up frame
        @(negedge sys_clk);
        enable = 1'b1;
        wait_fs(20);
        check1("pwr_disp", lcd_disp, 1'b1);
        check1("pwr_bl", lcd_bl, 1'b0);
        wait_fs(450);
        checkv("f1_hs_low", last_hs, 80);
        checkv("f1_vs_low", last_vs, 80);
        checkv("f1_de", last_de, 0);
        checkv("f1_req", last_req, 0);
        check1("f2_bl_on", lcd_bl, 1'b1);

        // 3: first RUN frame
        wait_fs(450);
        checkv("f2_req", last_req, 16);
        checkv("f2_de", last_de, 64);
        checkv("f2_rgb_count", rgb_last.size(), 16);
        for (int i = 0; i < 16 && i < rgb_last.size(); i++)
            checkv("f2_rgb_seq", int'(rgb_last[i]), int'(exp_rgb[i]));

        // 4: drop enable mid-frame, orderly shutdown
        repeat (150) @(negedge sys_clk);
        enable = 1'b0;
        wait_fs(450);
        checkv("drain_req", last_req, 16);
        checkv("drain_de", last_de, 64);
        check1("off_bl", lcd_bl, 1'b0);
        check1("off_disp", lcd_disp, 1'b1);
        wait_idle(450, w);
        checkv("off_frame_len", w, 400);
        check1("idle_disp", lcd_disp, 1'b0);
        check1("idle_vs", lcd_vs, 1'b1);

        // 5a: enable dropped during power-up
        enable = 1'b1;
        wait_fs(20);
        bl_seen = 0;
        repeat (100) @(negedge sys_clk);
        enable = 1'b0;
        wait_idle(450, w);
        check1("abort_bl_never", bl_seen, 1'b0);
        check1("abort_disp", lcd_disp, 1'b0);

        // 5b: enable toggled inside DRAIN
        enable = 1'b1;
        wait_fs(20);
        wait_fs(450);
        bl_low = 0;
        repeat (210) @(negedge sys_clk);
        enable = 1'b0;
        repeat (8) @(negedge sys_clk);
        enable = 1'b1;
        wait_fs(450);
        check1("redrain_bl_steady", bl_low, 1'b0);
        checkv("redrain_req", last_req, 16);
        checkv("redrain_de", last_de, 64);
        check1("redrain_busy", busy, 1'b1);

        // 6: asynchronous reset mid active line
        wait_de(450);
        repeat (2) @(negedge sys_clk);
        #3;
        sys_rst = 1'b0;
        #1;
        check1("rst_de", lcd_de, 1'b0);
        checkv("rst_rgb", int'(lcd_rgb), 0);
        check1("rst_hs", lcd_hs, 1'b1);
        check1("rst_vs", lcd_vs, 1'b1);
        check1("rst_bl", lcd_bl, 1'b0);
        check1("rst_disp", lcd_disp, 1'b0);
        check1("rst_busy", busy, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        wait_fs(20);
        check1("restart_disp", lcd_disp, 1'b1);
        check1("restart_bl", lcd_bl, 1'b0);
        wait_fs(450);
        check1("restart_bl_on", lcd_bl, 1'b1);

        repeat (5) @(negedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
